// File: rtl/vga_cpu_arbiter.sv
// Fits CPU accesses to VGA RAM into clock windows free of video fetches, holding the CPU
// on rdy until one access has run to completion without a fetch landing inside it.
//
// state  | meaning
// IDLE   | no CPU cycle in progress
// WAIT   | CPU request latched, waiting for a clock with no fetch pending
// ACCESS | CPU owns the RAM, cnt counts 0..ACCESS_CYCLES-1
// DONE   | access complete, rdy released until the CPU drops _vga_mem
module vga_cpu_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int RETRY_WIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   _reset,
  input  logic                   _vga_mem,
  input  logic                   _rd,
  input  logic                   _wr,
  input  logic [1:0]             addr,
  input  logic                   _bhe,
  input  logic                   fetch_pending,
  output logic                   rdy,
  output logic                   _cpu_ram_addr,
  output logic [3:0]             _cpu_ram,
  output logic [3:0]             _cs_ram_cpu,
  output logic [3:0]             _we_ram,
  output logic                   cpu_ram_dir,
  output logic                   rd_latch,
  output logic [RETRY_WIDTH-1:0] retries
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] CNT_LAST    = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_WE_LAST = CW'(ACCESS_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] vm_sync_q, vm_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [3:0]             lane_q, lane_d;
  logic [3:0]             pair_q, pair_d;
  logic                   write_q, write_d;
  logic                   done_q, done_d;
  logic [RETRY_WIDTH-1:0] retries_q, retries_d;
  logic                   cpu_ram_addr_n_q, cpu_ram_addr_n_d;
  logic [3:0]             cpu_ram_n_q, cpu_ram_n_d;
  logic [3:0]             cs_n_q, cs_n_d;
  logic [3:0]             we_n_q, we_n_d;
  logic                   dir_q, dir_d;
  logic                   rd_latch_q, rd_latch_d;

  logic vm_s, rd_s, wr_s, req, in_access;

  assign vm_s = vm_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign req  = ~vm_s & (~rd_s | ~wr_s);

  always_comb begin
    vm_sync_d = {vm_sync_q[SYNC_STAGES-2:0], _vga_mem};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], _rd};
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], _wr};
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    pair_d    = pair_q;
    write_d   = write_q;
    retries_d = retries_q;

    if (state_q != IDLE && vm_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_d = WAIT;
          pair_d  = addr[1] ? 4'b1100 : 4'b0011;
          lane_d  = addr[1] ? {~_bhe, ~addr[0], 2'b00} : {2'b00, ~_bhe, ~addr[0]};
          write_d = ~wr_s & rd_s;
        end
        WAIT: if (!fetch_pending) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
        ACCESS: begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else if (fetch_pending) begin
            // Fetch owns the next clock: back off and replay from cnt 0.
            state_d = WAIT;
            cnt_d   = '0;
            if (retries_q != '1) retries_d = retries_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    done_d    = (state_d == DONE);
    in_access = (state_d == ACCESS);

    // Outputs are computed from the next state so they are registered and align with state_q.
    cpu_ram_addr_n_d = ~in_access;
    cpu_ram_n_d      = in_access ? ~pair_q : 4'hF;
    cs_n_d           = in_access ? ~lane_q : 4'hF;
    we_n_d           = (in_access && write_q && cnt_d != '0 && cnt_d <= CNT_WE_LAST) ? ~lane_q : 4'hF;
    dir_d            = in_access ? write_q : dir_q;
    rd_latch_d       = in_access && !write_q && cnt_d == CNT_LAST;
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      vm_sync_q        <= '1;
      rd_sync_q        <= '1;
      wr_sync_q        <= '1;
      lane_q           <= '0;
      pair_q           <= '0;
      write_q          <= 1'b0;
      done_q           <= 1'b0;
      retries_q        <= '0;
      cpu_ram_addr_n_q <= 1'b1;
      cpu_ram_n_q      <= 4'hF;
      cs_n_q           <= 4'hF;
      we_n_q           <= 4'hF;
      dir_q            <= 1'b0;
      rd_latch_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      vm_sync_q        <= vm_sync_d;
      rd_sync_q        <= rd_sync_d;
      wr_sync_q        <= wr_sync_d;
      lane_q           <= lane_d;
      pair_q           <= pair_d;
      write_q          <= write_d;
      done_q           <= done_d;
      retries_q        <= retries_d;
      cpu_ram_addr_n_q <= cpu_ram_addr_n_d;
      cpu_ram_n_q      <= cpu_ram_n_d;
      cs_n_q           <= cs_n_d;
      we_n_q           <= we_n_d;
      dir_q            <= dir_d;
      rd_latch_q       <= rd_latch_d;
    end
  end

  assign rdy           = ~_reset | _vga_mem | done_q;
  assign _cpu_ram_addr = cpu_ram_addr_n_q;
  assign _cpu_ram      = cpu_ram_n_q;
  assign _cs_ram_cpu   = cs_n_q;
  assign _we_ram       = we_n_q;
  assign cpu_ram_dir   = dir_q;
  assign rd_latch      = rd_latch_q;
  assign retries       = retries_q;

endmodule

// File: tb/tb_vga_cpu_arbiter.sv
// Directed bench for vga_cpu_arbiter: cycle-exact expectations for reads, writes, fetch
// aborts, long fetch stalls, CPU abandonment, reset mid-write, retry saturation, back-to-back.
module tb_vga_cpu_arbiter;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       vga_mem_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'b00;
  logic       bhe_n = 1'b1;
  logic       fetch_pending = 1'b0;
  logic       rdy, cpu_ram_addr_n, dir, rd_latch;
  logic [3:0] cpu_ram_n, cs_n, we_n, retries;
  int total = 0;
  int bad = 0;

  always #10 clock = ~clock;

  vga_cpu_arbiter dut (
    .clock(clock), ._reset(reset_n), ._vga_mem(vga_mem_n), ._rd(rd_n), ._wr(wr_n),
    .addr(addr), ._bhe(bhe_n), .fetch_pending(fetch_pending), .rdy(rdy),
    ._cpu_ram_addr(cpu_ram_addr_n), ._cpu_ram(cpu_ram_n), ._cs_ram_cpu(cs_n),
    ._we_ram(we_n), .cpu_ram_dir(dir), .rd_latch(rd_latch), .retries(retries)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_start(input logic wr, input logic [1:0] a, input logic bhe);
    addr = a; bhe_n = bhe; rd_n = wr; wr_n = ~wr; vga_mem_n = 1'b0;
  endtask

  task automatic settle_idle();
    vga_mem_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; fetch_pending = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vga_mem_n = 1'b0;
    #15;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    total++; if ({cpu_ram_addr_n, cpu_ram_n, cs_n, we_n} !== 13'h1FFF) begin
      bad++; $display("FAIL reset_enables got=%h exp=1fff", {cpu_ram_addr_n, cpu_ram_n, cs_n, we_n}); end
    total++; if ({dir, rd_latch, retries} !== 6'b0) begin
      bad++; $display("FAIL reset_misc got=%b exp=000000", {dir, rd_latch, retries}); end
    vga_mem_n = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_read();
    logic in; logic [3:0] ec;
    cpu_start(1'b0, 2'b00, 1'b0);
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL read_rdy_drop got=%b exp=0", rdy); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      in = (c >= 4 && c <= 7);
      ec = in ? 4'b1100 : 4'hF;
      total++; if ({cpu_ram_addr_n, cpu_ram_n, cs_n, we_n} !== {~in, ec, ec, 4'hF}) begin
        bad++; $display("FAIL read_enables c=%0d got=%h exp=%h", c, {cpu_ram_addr_n, cpu_ram_n, cs_n, we_n}, {~in, ec, ec, 4'hF}); end
      total++; if ({rd_latch, rdy} !== {c == 7, c == 8}) begin
        bad++; $display("FAIL read_latch_rdy c=%0d got=%b exp=%b", c, {rd_latch, rdy}, {c == 7, c == 8}); end
    end
    settle_idle();
  endtask

  task automatic test_write();
    logic in; logic [3:0] ecs, eram, ewe;
    cpu_start(1'b1, 2'b11, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      in   = (c >= 4 && c <= 7);
      ecs  = in ? 4'b0111 : 4'hF;
      eram = in ? 4'b0011 : 4'hF;
      ewe  = (c == 5 || c == 6) ? 4'b0111 : 4'hF;
      total++; if ({cpu_ram_addr_n, cpu_ram_n, cs_n, we_n} !== {~in, eram, ecs, ewe}) begin
        bad++; $display("FAIL write_enables c=%0d got=%h exp=%h", c, {cpu_ram_addr_n, cpu_ram_n, cs_n, we_n}, {~in, eram, ecs, ewe}); end
      total++; if ({dir, rd_latch, rdy} !== {c >= 4, 1'b0, c == 8}) begin
        bad++; $display("FAIL write_dir_rdy c=%0d got=%b exp=%b", c, {dir, rd_latch, rdy}, {c >= 4, 1'b0, c == 8}); end
    end
    settle_idle();
  endtask

  task automatic test_abort();
    logic in;
    cpu_start(1'b0, 2'b00, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      in = (c == 4 || c == 5 || (c >= 7 && c <= 10));
      total++; if ({cpu_ram_addr_n, cs_n} !== {~in, in ? 4'b1100 : 4'hF}) begin
        bad++; $display("FAIL abort_enables c=%0d got=%h exp=%h", c, {cpu_ram_addr_n, cs_n}, {~in, in ? 4'b1100 : 4'hF}); end
      total++; if ({rd_latch, rdy, retries} !== {c == 10, c == 11, (c >= 6) ? 4'd1 : 4'd0}) begin
        bad++; $display("FAIL abort_status c=%0d got=%b exp=%b", c, {rd_latch, rdy, retries}, {c == 10, c == 11, (c >= 6) ? 4'd1 : 4'd0}); end
      fetch_pending = (c == 5);
    end
    settle_idle();
  endtask

  task automatic test_fetch_hold();
    logic in;
    cpu_start(1'b0, 2'b00, 1'b0);
    for (int c = 1; c <= 27; c++) begin
      tick();
      in = (c >= 23 && c <= 26);
      total++; if ({cpu_ram_addr_n, cs_n, cpu_ram_n} !== {~in, in ? 8'hCC : 8'hFF}) begin
        bad++; $display("FAIL hold_enables c=%0d got=%h exp=%h", c, {cpu_ram_addr_n, cs_n, cpu_ram_n}, {~in, in ? 8'hCC : 8'hFF}); end
      total++; if ({rd_latch, rdy} !== {c == 26, c == 27}) begin
        bad++; $display("FAIL hold_latch_rdy c=%0d got=%b exp=%b", c, {rd_latch, rdy}, {c == 26, c == 27}); end
      fetch_pending = (c >= 2 && c <= 21);
    end
    total++; if (retries !== 4'd1) begin bad++; $display("FAIL hold_retries got=%0d exp=1", retries); end
    settle_idle();
  endtask

  task automatic test_abandon();
    logic in;
    cpu_start(1'b0, 2'b00, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      in = (c >= 4 && c <= 6);
      total++; if ({cpu_ram_addr_n, cs_n, rd_latch} !== {~in, in ? 4'b1100 : 4'hF, 1'b0}) begin
        bad++; $display("FAIL abandon_enables c=%0d got=%b exp=%b", c, {cpu_ram_addr_n, cs_n, rd_latch}, {~in, in ? 4'b1100 : 4'hF, 1'b0}); end
      total++; if (rdy !== (c >= 5)) begin bad++; $display("FAIL abandon_rdy c=%0d got=%b exp=%b", c, rdy, c >= 5); end
      if (c == 4) begin vga_mem_n = 1'b1; rd_n = 1'b1; end
    end
    vga_mem_n = 1'b0;
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL abandon_stale_done got=%b exp=0", rdy); end
    settle_idle();
    // Reset in the middle of a write pulse.
    cpu_start(1'b1, 2'b01, 1'b0);
    repeat (5) tick();
    total++; if ({cs_n, we_n} !== 8'hDD) begin bad++; $display("FAIL rst_pre_we got=%h exp=dd", {cs_n, we_n}); end
    reset_n = 1'b0;
    #1;
    total++; if ({cpu_ram_addr_n, cpu_ram_n, cs_n, we_n} !== 13'h1FFF) begin
      bad++; $display("FAIL rst_mid_enables got=%h exp=1fff", {cpu_ram_addr_n, cpu_ram_n, cs_n, we_n}); end
    total++; if ({rdy, dir, rd_latch, retries} !== 7'b1000000) begin
      bad++; $display("FAIL rst_mid_misc got=%b exp=1000000", {rdy, dir, rd_latch, retries}); end
    vga_mem_n = 1'b1; wr_n = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_saturate();
    cpu_start(1'b0, 2'b00, 1'b0);
    repeat (4) tick();
    total++; if (cs_n !== 4'b1100) begin bad++; $display("FAIL sat_first_access got=%b exp=1100", cs_n); end
    for (int i = 0; i < 20; i++) begin
      fetch_pending = 1'b1;
      tick();
      if (i == 0) begin
        total++; if (cs_n !== 4'hF) begin bad++; $display("FAIL sat_abort_release got=%b exp=1111", cs_n); end
      end
      fetch_pending = 1'b0;
      tick();
      if (i == 13) begin
        total++; if (retries !== 4'hE) begin bad++; $display("FAIL sat_retries14 got=%h exp=e", retries); end
      end
    end
    total++; if (retries !== 4'hF) begin bad++; $display("FAIL sat_retries20 got=%h exp=f", retries); end
    repeat (3) tick();
    total++; if ({rd_latch, rdy} !== 2'b10) begin bad++; $display("FAIL sat_final_latch got=%b exp=10", {rd_latch, rdy}); end
    tick();
    total++; if ({rd_latch, rdy, cs_n} !== 6'b01_1111) begin
      bad++; $display("FAIL sat_done got=%b exp=011111", {rd_latch, rdy, cs_n}); end
  endtask

  task automatic test_back_to_back();
    logic in; logic [3:0] ecs, ewe;
    vga_mem_n = 1'b1; rd_n = 1'b1;
    repeat (3) tick();
    cpu_start(1'b1, 2'b10, 1'b1);
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL b2b_rdy_drop got=%b exp=0", rdy); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      in  = (c >= 4 && c <= 7);
      ecs = in ? 4'b1011 : 4'hF;
      ewe = (c == 5 || c == 6) ? 4'b1011 : 4'hF;
      total++; if ({cpu_ram_n, cs_n, we_n} !== {in ? 4'b0011 : 4'hF, ecs, ewe}) begin
        bad++; $display("FAIL b2b_enables c=%0d got=%h exp=%h", c, {cpu_ram_n, cs_n, we_n}, {in ? 4'b0011 : 4'hF, ecs, ewe}); end
      total++; if (rdy !== (c == 8)) begin bad++; $display("FAIL b2b_rdy c=%0d got=%b exp=%b", c, rdy, c == 8); end
    end
    settle_idle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_fetch_hold();
    test_abandon();
    test_saturate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
